// File: rtl/trdb_bmap_packet_emitter.sv
// trdb_bmap_packet_emitter: snapshots the branch map on full/emit triggers, flushes it,
// and queues format-1 packets in a small FIFO drained by a valid/ready handshake.
module trdb_bmap_packet_emitter #(
  parameter int XLEN             = 32,
  parameter int DEPTH            = 2,
  parameter int BRANCH_MAP_LEN   = 31,
  parameter int BRANCH_COUNT_LEN = 5,
  parameter int PKT_W            = 2 + BRANCH_COUNT_LEN + BRANCH_MAP_LEN + XLEN
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [BRANCH_MAP_LEN-1:0]   bm_map_i,
  input  logic [BRANCH_COUNT_LEN-1:0] bm_branches_i,
  input  logic                        bm_full_i,
  input  logic                        emit_req_i,
  input  logic [XLEN-1:0]             address_i,
  output logic                        bm_flush_o,
  output logic                        packet_valid_o,
  input  logic                        packet_ready_i,
  output logic [PKT_W-1:0]            packet_o,
  output logic [7:0]                  packet_len_o,
  output logic                        skip_o,
  output logic                        overflow_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = 2 + BRANCH_COUNT_LEN;
  logic [PKT_W-1:0] mem [DEPTH];
  logic [7:0] len_mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic skip_c, pop, space, accept;
  logic [BRANCH_COUNT_LEN-1:0] cnt_f;
  logic [7:0] cw, map_len, len_c;
  logic [BRANCH_MAP_LEN-1:0] map_m;
  logic [PKT_W-1:0] pkt_c;
  always_comb begin
    skip_c = emit_req_i & ~bm_full_i & (bm_branches_i == '0);
    pop = packet_valid_o & packet_ready_i;
    // a pop in the same cycle frees the slot, so a held full level is accepted then
    space = (cnt != CW'(DEPTH)) | pop;
    accept = rst_ni & (bm_full_i | emit_req_i) & space & ~skip_c;
    cnt_f = bm_full_i ? BRANCH_COUNT_LEN'(BRANCH_MAP_LEN) : bm_branches_i;
    cw = 8'(cnt_f);
    map_len = cw < 8'd2 ? 8'd1 : cw < 8'd10 ? 8'd9 : cw < 8'd18 ? 8'd17 : cw < 8'd26 ? 8'd25 : 8'd31;
    map_m = bm_map_i & ~({BRANCH_MAP_LEN{1'b1}} << cnt_f);
    len_c = emit_req_i ? 8'(HW) + map_len + 8'(XLEN) : 8'(HW + BRANCH_MAP_LEN);
    pkt_c = PKT_W'(2'b01) | (PKT_W'(emit_req_i ? cnt_f : '0) << 2) | (PKT_W'(map_m) << HW)
          | (emit_req_i ? PKT_W'(address_i) << (8'(HW) + map_len) : '0);
  end
  assign bm_flush_o = accept;
  assign skip_o = rst_ni & skip_c;
  assign packet_valid_o = vld[rd_ptr];
  assign packet_o = packet_valid_o ? mem[rd_ptr] : '0;
  assign packet_len_o = packet_valid_o ? len_mem[rd_ptr] : '0;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      end
      if (accept) begin
        mem[wr_ptr] <= pkt_c;
        len_mem[wr_ptr] <= len_c;
        vld[wr_ptr] <= 1'b1;
        wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      end
      cnt <= cnt + CW'(accept) - CW'(pop);
      overflow_o <= overflow_o | (emit_req_i & ~space & ~skip_c);
    end
  end
endmodule
